// File: rtl/rr_mem_pkg.sv
// Shared definitions for the rr on-chip RAM front-end: geometry, error word and the
// response record carried through the response FIFO.
package rr_mem_pkg;

    localparam int unsigned RR_ADDR_W    = 14;
    localparam int unsigned RR_DATA_W    = 32;
    localparam int unsigned RR_BE_W      = 4;
    localparam int unsigned RR_MEM_WORDS = 10240;

    localparam logic [RR_DATA_W-1:0] RR_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [RR_DATA_W-1:0] data;
        logic                 err;
    } rr_rsp_t;

endpackage

// File: rtl/rr_rsp_fifo.sv
// Synchronous FIFO for read responses; Depth must be a power of two so the pointers
// wrap naturally.
module rr_rsp_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [Width-1:0] data_i,
    input  logic            pop_i,
    output logic [Width-1:0] data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    always_comb begin
        full_o  = (count_q == CntW'(Depth));
        empty_o = (count_q == '0);
        count_o = count_q;
        data_o  = mem_q[rd_ptr_q];

        // A push into a full FIFO is only honoured when the head leaves the same cycle.
        push_en = push_i & (~full_o | pop_i);
        pop_en  = pop_i & ~empty_o;

        wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/rr_mem_cmd_adapter.sv
// Valid/ready command front-end for the rr single-port RAM: drives the RAM strobes,
// range-checks addresses and returns read data through a credit-managed response FIFO.
module rr_mem_cmd_adapter
    import rr_mem_pkg::*;
#(
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          MEM_WORDS = RR_MEM_WORDS,
    parameter logic [RR_DATA_W-1:0] ERR_DATA  = RR_ERR_DATA
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [RR_ADDR_W-1:0] cmd_addr,
    input  logic [RR_BE_W-1:0]   cmd_be,
    input  logic [RR_DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RR_DATA_W-1:0] rsp_data,
    output logic                 rsp_err,
    output logic [7:0]           err_count,
    output logic [RR_ADDR_W-1:0] mem_address,
    output logic [RR_BE_W-1:0]   mem_byteenable,
    output logic [RR_DATA_W-1:0] mem_writedata,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic                 mem_clken,
    input  logic [RR_DATA_W-1:0] mem_readdata
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            acc, oor, rd_acc;
    logic            rd_pending_q, rd_pending_d;
    logic            rd_oor_q, rd_oor_d;
    logic [7:0]      err_count_q, err_count_d;
    rr_rsp_t         push_rsp, head_rsp;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    always_comb begin
        // The in-flight read owns a FIFO slot, so its push can never overflow.
        cmd_ready = ~reset & ((32'(fifo_count) + 32'(rd_pending_q)) < DEPTH);
        acc       = cmd_valid & cmd_ready;
        oor       = 32'(cmd_addr) >= MEM_WORDS;
        rd_acc    = acc & ~cmd_write;

        mem_chipselect = acc & ~oor;
        mem_write      = acc & cmd_write & ~oor;
        mem_address    = cmd_addr;
        mem_byteenable = cmd_be;
        mem_writedata  = cmd_wdata;
        mem_clken      = 1'b1;

        rd_pending_d = rd_acc;
        rd_oor_d     = rd_acc ? oor : rd_oor_q;

        err_count_d = err_count_q;
        if (acc && oor && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        push_rsp.data = rd_oor_q ? ERR_DATA : mem_readdata;
        push_rsp.err  = rd_oor_q;
        // A read issued just before reset must not land in the freshly cleared FIFO.
        fifo_push = rd_pending_q & ~reset;

        rsp_valid = ~fifo_empty;
        rsp_data  = fifo_empty ? '0 : head_rsp.data;
        rsp_err   = ~fifo_empty & head_rsp.err;
        fifo_pop  = rsp_valid & rsp_ready;
        err_count = err_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            rd_oor_q     <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_oor_q     <= rd_oor_d;
            err_count_q  <= err_count_d;
        end
    end

    rr_rsp_fifo #(
        .Width ($bits(rr_rsp_t)),
        .Depth (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  (push_rsp),
        .pop_i   (fifo_pop),
        .data_o  (head_rsp),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    no_overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: doc/rr_mem_cmd_adapter.md
# rr_mem_cmd_adapter

Upstream front-end for the `rr` on-chip 32-bit single-port RAM (10240 words, 14-bit word address, byte enables, one-cycle unregistered read latency). It converts a valid/ready command stream into the RAM's chipselect/write strobes and captures read data into a small response FIFO. The FIFO gives the consumer real backpressure on a memory that has none. It also range-checks addresses against the populated depth and flags out-of-range accesses.

## Interface
- `DEPTH`, 4: response FIFO entries; power of two, ≥2.
- `MEM_WORDS`, 10240: populated words; addresses ≥ this are out of range.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned for out-of-range reads.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: adapter accepts the command this cycle.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 14: word address.
- `cmd_be` in 4: byte enables (writes only).
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: read response available.
- `rsp_ready` in 1: consumer takes response.
- `rsp_data` out 32: read data.
- `rsp_err` out 1: response came from an out-of-range read.
- `err_count` out 8: saturating count of out-of-range commands.
- `mem_address` out 14, `mem_byteenable` out 4, `mem_writedata` out 32: RAM port.
- `mem_chipselect` out 1, `mem_write` out 1, `mem_clken` out 1: RAM strobes.
- `mem_readdata` in 32: RAM read data.

## Operation
- Accept: `acc = cmd_valid & cmd_ready`.
- `cmd_ready = ~reset & (fifo_count + rd_pending < DEPTH)`.
  - Does not depend on `cmd_write`, so writes also stall when credits are exhausted.
- Range check: `oor = cmd_addr >= MEM_WORDS`.
- RAM drive, combinational from the accepted command:
  - `mem_chipselect = acc & ~oor`.
  - `mem_write = acc & cmd_write & ~oor`.
  - Address, byte enables and write data pass straight through.
  - `mem_clken` is tied 1.
- Out-of-range write: dropped, with no RAM access. `err_count` increments.
- Out-of-range read: no RAM access. A response is still produced: `rsp_data = ERR_DATA`, `rsp_err = 1`. `err_count` increments.
- Read tracking registers, all loaded on every accepted read:
  - `rd_pending` (1 bit).
  - `rd_oor` (1 bit).
- The cycle after an accepted read, the FIFO pushes one entry:
  - `{mem_readdata, 0}` when `rd_oor = 0`.
  - `{ERR_DATA, 1}` when `rd_oor = 1`.
- FIFO pop on `rsp_valid & rsp_ready`.
  - Push and pop may occur in the same cycle; count is then unchanged.
- Credit rule: a push can never overflow the FIFO, because the pending read holds a credit. Overflow is an assertion failure.
- `err_count` saturates at 255.
- Reset mid-operation:
  - FIFO emptied, `rd_pending` cleared.
  - A RAM read issued in the cycle before reset is discarded.
  - `err_count` cleared.

## Timing
- Reset values:
  - `cmd_ready = 0` while `reset` is high.
  - `rsp_valid = 0`, `rsp_data = 0`, `rsp_err = 0`, `err_count = 0`.
  - `mem_chipselect = 0`, `mem_write = 0`.
- Read accepted in cycle N:
  - RAM samples the address at the end of N.
  - `mem_readdata` is valid in N+1 and is pushed at the end of N+1.
  - `rsp_valid = 1` in N+2. Fixed minimum latency is 2.
- Throughput: with `rsp_ready` held high, one read per cycle sustained (occupancy ≤ 2 < `DEPTH`).
- Write accepted in N: RAM updated at the end of N. A read accepted in N+1 returns the new data.
- With `rsp_ready` low, exactly `DEPTH` reads are accepted, then `cmd_ready` falls.
  - `cmd_ready` rises the cycle after the first pop.
- Response order equals read acceptance order.

## Structure
- Shared package `rr_mem_pkg`:
  - `RR_ADDR_W=14`, `RR_DATA_W=32`, `RR_BE_W=4`, `RR_MEM_WORDS=10240`, `RR_ERR_DATA`.
  - Response struct `{data[31:0], err}`.
- One sub-module `rr_rsp_fifo`: synchronous FIFO, parameterised width/depth.
  - Pointers wrap modulo `DEPTH`.
  - Count width `$clog2(DEPTH)+1`.
  - Ports: push, pop, full, empty, count.

## Test plan
- Write addr 0x0005 data 0x1234_5678 be 4'b1111, then read 0x0005 → `rsp_data = 0x1234_5678`, `rsp_err = 0`, 2 cycles after the read accept.
- Write 0xFFFF_FFFF, then write 0x0000_00AA with be 4'b0001, then read → `0xFFFF_FFAA`.
- Read addr 10240 → no `mem_chipselect`, `rsp_data = 0xDEAD_BEEF`, `rsp_err = 1`, `err_count = 1`.
- `rsp_ready = 0` while issuing reads to 0..7 → exactly 4 accepted, `cmd_ready = 0`. Release → responses 0..3 in order, remaining reads then accepted.
- Back-to-back reads to 0..15 with `rsp_ready = 1` → 16 consecutive accepts, 16 consecutive responses starting 2 cycles later.
- Assert `reset` one cycle after a read accept → no response ever appears. `rsp_valid`, `err_count` and the FIFO count are all 0 the cycle after reset.
